// File: rtl/bram_word_loader.sv
// bram_word_loader
//   Fill stage for the result/operand BRAM. Packs LANES = DATA_WIDTH/IN_WIDTH
//   input beats (first beat in the lowest lane) into one BRAM word. Each packed
//   word is written through port A at base_addr, base_addr+1, ... (modulo the
//   address space). done pulses once after the final word has been written.
//
//   Optional build macro: LOADER_CHECKSUM_EN adds a running XOR of all words
//   written by the current load.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             load request, sampled only in IDLE
//   abort             cancels an active load (partial word discarded, no done)
//   base_addr         first BRAM address, captured on start
//   num_words         number of words to write (0..2^ADDR_WIDTH), captured on start
//   s_data/s_valid    input beat stream
//   s_ready           high while loading; the loader never stalls mid-load
//   ram_en/ram_we     port A write strobe (one cycle per word)
//   ram_addr/ram_din  port A address / write data
//   busy              high while in LOAD
//   done              one-cycle completion pulse
//   checksum          (LOADER_CHECKSUM_EN only) XOR of written words
module bram_word_loader #(
    parameter int DATA_WIDTH = 96,
    parameter int IN_WIDTH   = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned LANES  = DATA_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } state_t;

    state_t state, state_next;

    logic [LANE_W-1:0]     lane;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH:0]   num_cap;
    logic [ADDR_WIDTH-1:0] base_cap;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  accept;
    logic                  last_lane;
    logic                  last_word;
    logic                  write_fire;

    // Handshake and word-boundary decode. abort has priority over a final lane.
    always_comb begin
        accept     = s_valid & s_ready;
        last_lane  = (lane == LANE_W'(LANES - 1));
        last_word  = (word_cnt == (num_cap - (ADDR_WIDTH + 1)'(1)));
        write_fire = accept & last_lane & ~abort;
    end

    // Word being assembled with the current beat merged into its lane.
    always_comb begin
        word_next = word_buf;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                word_next[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (write_fire && last_word) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state == LOAD);
    end

    // Datapath and registered port A / done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= '0;
            word_cnt <= '0;
            num_cap  <= '0;
            base_cap <= '0;
            word_buf <= '0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            done   <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        base_cap <= base_addr;
                        num_cap  <= num_words;
                        lane     <= '0;
                        word_cnt <= '0;
                        word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        lane <= '0;
                    end else if (accept) begin
                        if (last_lane) begin
                            lane     <= '0;
                            ram_en   <= 1'b1;
                            ram_we   <= 1'b1;
                            ram_addr <= base_cap + word_cnt[ADDR_WIDTH-1:0];
                            ram_din  <= word_next;
                            word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
`ifdef LOADER_CHECKSUM_EN
                            checksum <= checksum ^ word_next;
`endif
                        end else begin
                            lane     <= lane + LANE_W'(1);
                            word_buf <= word_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
